// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: state encoding, sizing helpers and default parameters shared by conv_frame_ctrl and conv_out_fmt
package conv_ctrl_pkg;
  localparam int DEF_IMG_W  = 512;
  localparam int DEF_IMG_H  = 512;
  localparam int DEF_K      = 3;
  localparam int DEF_PIX_W  = 16;
  localparam int DEF_RES_W  = 20;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_GAP    = 25;
  localparam int DEF_ADDR_W = 19;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, GAP_WAIT, DRAIN, FIN} state_t;
  function automatic longint n_pix(input longint w, input longint h);
    return w * h;
  endfunction
  function automatic longint n_out(input longint w, input longint h, input longint k);
    return (w - k + 1) * (h - k + 1);
  endfunction
endpackage

// File: rtl/conv_out_fmt.sv
// conv_out_fmt: registered result-to-output conversion and write stage; CONV_CTRL_SAT_EN selects clamping over truncation
module conv_out_fmt
  import conv_ctrl_pkg::*;
#(
  parameter int RES_W  = DEF_RES_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [RES_W-1:0]  result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]  wr_data
);
  logic [OUT_W-1:0] fmt;
`ifdef CONV_CTRL_SAT_EN
  localparam logic signed [RES_W-1:0] MAX = RES_W'((64'd1 << OUT_W) - 1);
  assign fmt = result[RES_W-1] ? '0 : ($signed(result) > MAX) ? '1 : result[OUT_W-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^result[RES_W-1:OUT_W];
  assign fmt = result[OUT_W-1:0];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= valid;
      if (valid) begin
        wr_addr <= addr;
        wr_data <= fmt;
      end
    end
  end
endmodule

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: fetches a frame, paces pixels into the convolution engine every GAP cycles and stores its results
// Build option CONV_CTRL_SAT_EN: clamp written results to [0, 2^OUT_W-1] instead of truncating.
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int RES_W  = DEF_RES_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int GAP    = DEF_GAP,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  eng_din,
  output logic              eng_i_en,
  input  logic              eng_o_en,
  input  logic [RES_W-1:0]  eng_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]  wr_data
);
  localparam longint NPIX = n_pix(IMG_W, IMG_H);
  localparam longint NOUT = n_out(IMG_W, IMG_H, K);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] N_OUT = ADDR_W'(NOUT);
  localparam int GW = $clog2(GAP);
  if (NPIX - 1 >= (longint'(1) << ADDR_W) || NOUT >= (longint'(1) << ADDR_W) || GAP < 3) begin : g_cfg_chk
    $error("conv_frame_ctrl: ADDR_W too narrow for the frame, or GAP < 3");
  end
  state_t state, nxt;
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [GW-1:0] gap_cnt;
  logic [PIX_W-1:0] din_q;
  logic accept, wr_ok, ovr;
  assign accept = state == IDLE && start;
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign rd_en = state == FETCH;
  assign rd_addr = rd_ptr;
  assign eng_i_en = state == ISSUE;
  assign eng_din = eng_i_en ? rd_data : din_q;
  assign wr_ok = busy && eng_o_en && wr_ptr != N_OUT;
  assign ovr = busy && eng_o_en && wr_ptr == N_OUT;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start ? FETCH : IDLE;
      FETCH:    nxt = ISSUE;
      ISSUE:    nxt = (rd_ptr == LAST_PIX) ? DRAIN : GAP_WAIT;
      GAP_WAIT: nxt = (gap_cnt == '0) ? FETCH : GAP_WAIT;
      // the last accepted result is still in the write stage while wr_en is high
      DRAIN:    nxt = (wr_ptr == N_OUT && !wr_en) ? FIN : DRAIN;
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      gap_cnt <= '0;
      err     <= 1'b0;
      din_q   <= '0;
    end else begin
      state <= nxt;
      if (accept) rd_ptr <= '0;
      else if (state == ISSUE && rd_ptr != LAST_PIX) rd_ptr <= rd_ptr + 1'b1;
      if (accept) wr_ptr <= '0;
      else if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (accept) err <= 1'b0;
      else if (ovr) err <= 1'b1;
      // GAP_WAIT spans GAP-2 cycles so FETCH+ISSUE+GAP_WAIT is exactly GAP
      if (state == ISSUE) begin
        gap_cnt <= GW'(GAP - 3);
        din_q   <= rd_data;
      end else if (state == GAP_WAIT && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end
  conv_out_fmt #(.RES_W(RES_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) u_fmt (
    .clk(clk), .rst(rst), .valid(wr_ok), .addr(wr_ptr), .result(eng_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: randomized scoreboard bench for conv_frame_ctrl on an 8x6 frame with GAP=4
module tb_conv_frame_ctrl;
  localparam int IMG_W = 8, IMG_H = 6, K = 3, PIX_W = 16, RES_W = 20, OUT_W = 8, GAP = 4, ADDR_W = 19;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NOUT = (IMG_W - K + 1) * (IMG_H - K + 1);
  logic clk = 0, rst = 1, start = 0, eng_o_en = 0;
  logic [RES_W-1:0] eng_result = '0;
  logic [PIX_W-1:0] rd_data = '0;
  logic busy, done, err, rd_en, eng_i_en, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [PIX_W-1:0] eng_din;
  logic [OUT_W-1:0] wr_data;
  always #5 clk = ~clk;
  conv_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIX_W(PIX_W), .RES_W(RES_W),
                    .OUT_W(OUT_W), .GAP(GAP), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .eng_din(eng_din), .eng_i_en(eng_i_en),
    .eng_o_en(eng_o_en), .eng_result(eng_result), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  logic [PIX_W-1:0] ram [NPIX];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr[5:0]];
  int compared = 0, mism = 0;
  int cyc = 0, issue_cnt = 0, wr_cnt = 0, done_cnt = 0, last_issue = -1, done_cyc = 0, exp_wr = 0;
  logic err_at_done = 0;
  logic [PIX_W-1:0] pix_q[$];
  logic [ADDR_W+OUT_W-1:0] wr_q[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [OUT_W-1:0] fmt(input int r);
`ifdef CONV_CTRL_SAT_EN
    return (r < 0) ? '0 : (r > 255) ? 8'hFF : OUT_W'(r);
`else
    return OUT_W'(r);
`endif
  endfunction
  function automatic int rnd();
    return int'($urandom_range(2000)) - 1000;
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (eng_i_en) begin
      if (pix_q.size() == 0) begin
        compared++; mism++;
        $display("FAIL extra_issue: eng_din 0x%0h with no pixel expected", eng_din);
      end else chk("eng_din", eng_din, pix_q.pop_front());
      if (last_issue >= 0) chk("issue_gap", cyc - last_issue, GAP);
      last_issue = cyc;
      issue_cnt++;
    end
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        compared++; mism++;
        $display("FAIL extra_write: addr %0d data 0x%0h with no write expected", wr_addr, wr_data);
      end else chk("write_addr_data", {wr_addr, wr_data}, wr_q.pop_front());
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      err_at_done = err;
    end
  end
  task automatic wait_issue(input int k);
    int t = 0;
    while (issue_cnt < k && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk("issue_reached", issue_cnt >= k, 1);
  endtask
  task automatic put_res(input int r);
    @(posedge clk);
    #1 eng_o_en = 1;
    eng_result = RES_W'(r);
    if (exp_wr < NOUT) begin
      wr_q.push_back({ADDR_W'(exp_wr), fmt(r)});
      exp_wr++;
    end
  endtask
  task automatic end_res();
    @(posedge clk);
    #1 eng_o_en = 0;
  endtask
  task automatic start_frame();
    pix_q.delete();
    wr_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      ram[i] = PIX_W'($urandom);
      pix_q.push_back(ram[i]);
    end
    exp_wr = 0; issue_cnt = 0; wr_cnt = 0; last_issue = -1;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("start_busy", busy, 1);
    chk("start_err_clear", err, 0);
    chk("start_rd_en", rd_en, 1);
    chk("start_rd_addr", rd_addr, 0);
  endtask
  // kind: 0 nominal, 1 saturation, 2 early outputs, 3 overrun, 4 start while busy
  task automatic run_frame(input int kind);
    int d0;
    d0 = done_cnt;
    start_frame();
    fork
      begin
        if (kind == 1) begin
          wait_issue(1);
          put_res(-5); put_res(300); put_res(128);
          for (int i = 0; i < NOUT - 3; i++) put_res(rnd());
          end_res();
        end else if (kind == 2 || kind == 3) begin
          wait_issue(2);
          for (int i = 0; i < NOUT + (kind == 3 ? 1 : 0); i++) put_res(rnd());
          end_res();
        end else begin
          if (kind == 4) begin
            wait_issue(5);
            #1 start = 1;
            @(posedge clk);
            #1 start = 0;
          end
          for (int k = NOUT + 1; k <= NPIX; k++) begin
            wait_issue(k);
            put_res(rnd());
            end_res();
          end
        end
      end
      begin
        int t = 0;
        while (!done && t < 3000) begin
          @(negedge clk);
          t++;
        end
        chk("done_seen", done, 1);
        if (kind == 4) begin
          start = 1;
          @(posedge clk);
          #1 start = 0;
          chk("fin_start_ignored", busy, 0);
        end
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("issue_count", issue_cnt, NPIX);
    chk("write_count", wr_cnt, NOUT);
    chk("err_at_done", err_at_done, kind == 3);
    chk("pixels_left", pix_q.size(), 0);
    chk("writes_left", wr_q.size(), 0);
    chk("idle_after", busy, 0);
    if (kind == 2) chk("done_latency_ok", (done_cyc - last_issue) inside {[1:2]}, 1);
    if (kind == 3) chk("err_sticky", err, 1);
  endtask
  task automatic reset_mid_frame();
    int d0, i0;
    start_frame();
    d0 = done_cnt;
    wait_issue(10);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("rst_ctrl", {busy, done, err, rd_en, eng_i_en, wr_en}, 0);
    chk("rst_bus", {rd_addr, eng_din, wr_addr, wr_data}, 0);
    pix_q.delete();
    wr_q.delete();
    i0 = issue_cnt;
    repeat (300) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_issue", issue_cnt - i0, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, done, err, rd_en, eng_i_en, wr_en}, 0);
    chk("reset_bus", {rd_addr, eng_din, wr_addr, wr_data}, 0);
    rst = 0;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(0);
    reset_mid_frame();
    run_frame(0);
    run_frame(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
